channel_stats: RTL
==================

# channel_stats

Streaming per-channel statistics block for the color-transfer path. It accumulates the sum and sum-of-squares of one 8-bit color channel over a frame. At end of frame it computes the integer mean and variance with a shared sequential divider. It then presents the 32-bit variance to the downstream `sqrt32` instance, together with a one-cycle start pulse that drives that instance's `reset`.

## Interface
- `PIX_W`, default 8: pixel width in bits.
- `CNT_W`, default 21: pixel-counter width; maximum frame size is 2^20 pixels.
- `SUM_W`, default 36: width of the sum-of-squares accumulator and of the divider dividend.
- `clk`, input, 1: clock.
- `reset`, input, 1: reset, asynchronous, active-high.
- `sof`, input, 1: start of frame; clears the accumulators; accepted in any state.
- `pix_valid`, input, 1: `pix` is valid this cycle.
- `pix`, input, PIX_W: channel sample.
- `eof`, input, 1: last pixel of the frame; qualified by `pix_valid`.
- `busy`, output, 1: high in the DIV_MEAN, DIV_SQ and FINISH states.
- `out_valid`, output, 1: results valid; held high until the next `sof` or `reset`.
- `mean`, output, PIX_W: floor(sum/N).
- `variance`, output, 32: floor(sumsq/N) − mean², zero-extended; feeds `sqrt32.x`.
- `sqrt_start`, output, 1: one-cycle pulse; drives `sqrt32.reset`.

## Operation
- States: IDLE, ACCUM, DIV_MEAN, DIV_SQ, FINISH, DONE.
- **IDLE and DONE, on `sof`:**
  - Clear `sum`, `sumsq` and `cnt`, and clear `out_valid`.
  - Go to ACCUM.
  - If `pix_valid` is high in the same cycle, that pixel is the first sample of the frame.
- **ACCUM:**
  - Each cycle with `pix_valid`: `sum += pix`, `sumsq += pix*pix`, `cnt += 1`.
  - `pix_valid` & `eof`: include that pixel, then go to DIV_MEAN.
  - `sof` in ACCUM restarts the frame: clear, then accumulate the current pixel if it is valid.
  - `cnt` saturates at 2^20. Pixels beyond that are dropped and do not change any accumulator.
- **Divider:** restoring divider, one quotient bit per cycle, exactly 36 iterations. Divisor is `cnt`, zero-extended.
  - DIV_MEAN divides `sum`, zero-extended to 36 bits; the low 8 quotient bits are the mean.
  - DIV_SQ divides `sumsq`; the quotient is `msq`.
- **FINISH:**
  - `variance = msq − mean*mean`. If the result would be negative it is clamped to 0; this cannot happen with correct arithmetic but is still required.
  - Register `mean` and `variance`.
  - Assert `out_valid` and pulse `sqrt_start`.
  - Go to DONE.
- **Inputs while busy:**
  - `pix_valid` and `eof` are ignored in DIV_MEAN, DIV_SQ and FINISH.
  - `sof` while busy aborts the division and enters ACCUM as above. `out_valid` stays low and no `sqrt_start` pulse is produced.
- `eof` without `pix_valid` is ignored, so N ≥ 1 always holds at division time.
- **Reset values:**
  - All accumulators and `cnt` = 0.
  - State = IDLE.
  - `busy`, `out_valid` and `sqrt_start` = 0.
  - `mean` = 0 and `variance` = 0.

## Timing
- **Edge numbering:** cycle k is the interval after clock edge k, for k ≥ 0. Edge 0 is the edge at which `pix_valid` & `eof` are sampled.
- **Accumulate latency:** accumulation has 1-cycle latency; the eof pixel is in the accumulators after edge 0.
- **Divider occupancy:**
  - DIV_MEAN occupies cycles 0–35.
  - DIV_SQ occupies cycles 36–71.
  - FINISH is cycle 72.
- **Outputs:**
  - `out_valid` rises and `sqrt_start` is high for cycle 73 only.
  - `mean` and `variance` are stable from cycle 73 until `out_valid` falls.
- **`busy`:** high in cycles 0–72.
- **Downstream:** `sqrt32` begins iterating on cycle 74. Its result is ready 16 cycles later, when its `rdy` rises.
- **Back-to-back frames:** a `sof` in DONE is accepted immediately. `out_valid` drops on the cycle after the `sof` edge.
- **Reset mid-operation:** all state returns to the reset values asynchronously. No `sqrt_start` pulse is produced.

## Structure
- **Package `stats_pkg`:**
  - Widths `PIX_W`, `CNT_W` and `SUM_W`, plus `DIV_ITERS` = 36 and `MAX_PIX` = 2^20.
  - The state enum `stats_state_t`.
- **Sub-module `seq_divider`:**
  - Ports: `start`, dividend[35:0], divisor[20:0], `quotient`, `done`.
  - Instantiated once and reused for DIV_MEAN and DIV_SQ.
  - Takes a local `abort` input so that a `sof` while busy can cancel it.
- **Top level:** the accumulators, saturation logic, FSM and FINISH arithmetic (one 8×8 multiply and one subtract) live in `channel_stats`.

## Test plan
- **Single pixel:** 1 pixel, value 7, with `eof` → mean=7, variance=0. `out_valid` and `sqrt_start` rise 73 cycles after the eof edge.
- **Small ramp:** pixels 1,2,3,4, `eof` on the 4th → sum=10, sumsq=30; mean=2, variance=7−4=3.
- **Extremes:** pixels 0 and 255 → mean=127, msq=32512, variance=16383. Chained with `sqrt32`, y=127.
- **Constant frame:** 4 pixels, each 100 → mean=100, variance=0. Chained `sqrt32` y=0x0100, because of its zero guard.
- **Abort by `sof`:** `sof` at cycle 20 of DIV_MEAN, then 2 pixels of 50 with `eof` → no pulse for the aborted frame. Then a single valid result: mean=50, variance=0.
- **Reset and ignored inputs:**
  - `reset` asserted during DIV_SQ → all outputs return to their reset values immediately.
  - `pix_valid` while busy is ignored; the following frame produces the correct result.

Source files
------------

// File: rtl/channel_stats_pkg.sv
// stats_pkg: shared widths, divider length and FSM encoding for channel_stats.
//   PIX_W     - pixel / mean width
//   CNT_W     - pixel counter width (holds MAX_PIX)
//   SUM_W     - accumulator and divider dividend width
//   DIV_ITERS - quotient bits produced per division
//   MAX_PIX   - saturation point of the pixel counter
package stats_pkg;

  localparam int unsigned PIX_W     = 8;
  localparam int unsigned CNT_W     = 21;
  localparam int unsigned SUM_W     = 36;
  localparam int unsigned DIV_ITERS = 36;
  localparam int unsigned MAX_PIX   = 1 << 20;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ACCUM    = 3'd1,
    DIV_MEAN = 3'd2,
    DIV_SQ   = 3'd3,
    FINISH   = 3'd4,
    DONE     = 3'd5
  } stats_state_t;

endpackage

// File: rtl/channel_stats_if.sv
// channel_stats_if: pixel stream in, frame statistics out.
//   sof, pix_valid, pix, eof          - stream from the colour path (master -> slave)
//   busy, out_valid, mean, variance,
//   sqrt_start                        - results towards sqrt32 (slave -> master)
interface channel_stats_if #(
  parameter int unsigned PIX_W = stats_pkg::PIX_W
);

  logic             sof;
  logic             pix_valid;
  logic [PIX_W-1:0] pix;
  logic             eof;
  logic             busy;
  logic             out_valid;
  logic [PIX_W-1:0] mean;
  logic [31:0]      variance;
  logic             sqrt_start;

  modport master (
    output sof, pix_valid, pix, eof,
    input  busy, out_valid, mean, variance, sqrt_start
  );

  modport slave (
    input  sof, pix_valid, pix, eof,
    output busy, out_valid, mean, variance, sqrt_start
  );

endinterface

// File: rtl/channel_stats_divider.sv
// seq_divider: restoring divider, one quotient bit per cycle, DVD_W steps.
//   start    - load dividend/divisor and perform the first step in the same cycle
//   abort    - cancel a division in flight (wins over start)
//   dividend - numerator, sampled only while start is high
//   divisor  - denominator, must stay stable for the whole division
//   quotient - final after the last step; shift register while iterating
//   done     - high during the final step cycle so a caller can chain without a bubble
module seq_divider
  import stats_pkg::*;
#(
  parameter int unsigned DVD_W = SUM_W,
  parameter int unsigned DVS_W = CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic [DVD_W-1:0] quotient,
  output logic             done
);

  localparam int unsigned IT_W = $clog2(DVD_W + 1);

  logic [DVS_W-1:0] rem_q;
  logic [IT_W-1:0]  iter_q;

  logic [DVS_W-1:0] rem_src;
  logic [DVS_W-1:0] rem_nxt;
  logic [DVD_W-1:0] dq_src;
  logic [DVS_W:0]   trial;
  logic             ge;
  logic             step;
  logic [IT_W-1:0]  iter_nxt;

  // One restoring step; dividend bits shift out of the top as quotient bits shift in.
  always_comb begin
    rem_src  = start ? '0 : rem_q;
    dq_src   = start ? dividend : quotient;
    trial    = {rem_src, dq_src[DVD_W-1]};
    ge       = trial >= {1'b0, divisor};
    rem_nxt  = ge ? DVS_W'(trial - {1'b0, divisor}) : DVS_W'(trial);
    step     = !abort && (start || (iter_q != '0));
    iter_nxt = start ? IT_W'(DVD_W - 1) : iter_q - IT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q    <= '0;
      quotient <= '0;
      iter_q   <= '0;
      done     <= 1'b0;
    end else if (abort) begin
      iter_q <= '0;
      done   <= 1'b0;
    end else if (step) begin
      rem_q    <= rem_nxt;
      quotient <= {dq_src[DVD_W-2:0], ge};
      iter_q   <= iter_nxt;
      done     <= (iter_nxt == IT_W'(1));
    end
  end

endmodule

// File: rtl/channel_stats.sv
// channel_stats: per-frame mean and variance of one colour channel.
//   clk, reset    - clock, asynchronous active-high reset
//   bus (slave)   - sof/pix_valid/pix/eof in; busy/out_valid/mean/variance/sqrt_start out
// Sums pixels and squared pixels over a frame, then divides both by the pixel
// count on one shared divider and presents variance with a start pulse for sqrt32.
module channel_stats #(
  parameter int unsigned PIX_W = stats_pkg::PIX_W,
  parameter int unsigned CNT_W = stats_pkg::CNT_W,
  parameter int unsigned SUM_W = stats_pkg::SUM_W
) (
  input  logic           clk,
  input  logic           reset,
  channel_stats_if.slave bus
);

  import stats_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PIX);

  stats_state_t     state_q;
  stats_state_t     state_nxt;
  logic [SUM_W-1:0] sum_q;
  logic [SUM_W-1:0] sumsq_q;
  logic [CNT_W-1:0] cnt_q;
  logic [PIX_W-1:0] mean_tmp_q;
  logic [PIX_W-1:0] mean_q;
  logic [31:0]      variance_q;
  logic             busy_q;
  logic             out_valid_q;
  logic             sqrt_start_q;
  logic             div_start_q;

  logic               take;
  logic               abort;
  logic               finish;
  logic               busy_nxt;
  logic               div_start_nxt;
  logic               div_done;
  logic [SUM_W-1:0]   dividend;
  logic [SUM_W-1:0]   quotient;
  logic [SUM_W-1:0]   pix_ext;
  logic [SUM_W-1:0]   pix_sq;
  logic [2*PIX_W-1:0] mean_sq;
  logic [31:0]        var_calc;

  // Next state and per-cycle control; sof overrides everything and restarts the frame.
  always_comb begin
    state_nxt     = state_q;
    take          = 1'b0;
    abort         = 1'b0;
    finish        = 1'b0;
    busy_nxt      = 1'b0;
    div_start_nxt = 1'b0;
    case (state_q)
      IDLE, DONE: ;
      ACCUM: begin
        take = bus.pix_valid && (cnt_q != CNT_MAX);
        if (bus.pix_valid && bus.eof) state_nxt = DIV_MEAN;
      end
      DIV_MEAN: if (div_done) state_nxt = DIV_SQ;
      DIV_SQ:   if (div_done) state_nxt = FINISH;
      FINISH: begin
        finish    = 1'b1;
        state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
    if (bus.sof) begin
      abort  = busy_q;
      finish = 1'b0;
      take   = bus.pix_valid;
      // A one-pixel frame can arrive with sof and eof together; do not lose its eof.
      state_nxt = (bus.pix_valid && bus.eof) ? DIV_MEAN : ACCUM;
    end
    busy_nxt      = (state_nxt == DIV_MEAN) || (state_nxt == DIV_SQ) || (state_nxt == FINISH);
    div_start_nxt = ((state_nxt == DIV_MEAN) && (bus.sof || (state_q != DIV_MEAN))) ||
                    ((state_q == DIV_MEAN) && (state_nxt == DIV_SQ));
  end

  // Finish arithmetic: msq - mean^2, clamped at zero.
  always_comb begin
    pix_ext  = SUM_W'(bus.pix);
    pix_sq   = pix_ext * pix_ext;
    mean_sq  = (2*PIX_W)'(mean_tmp_q) * (2*PIX_W)'(mean_tmp_q);
    var_calc = (quotient >= SUM_W'(mean_sq)) ? 32'(quotient - SUM_W'(mean_sq)) : '0;
    dividend = (state_q == DIV_SQ) ? sumsq_q : sum_q;
  end

  // Accumulators; a sof restarts them with the current pixel if it is valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q   <= '0;
      sumsq_q <= '0;
      cnt_q   <= '0;
    end else if (bus.sof) begin
      sum_q   <= take ? pix_ext : '0;
      sumsq_q <= take ? pix_sq : '0;
      cnt_q   <= take ? CNT_W'(1) : '0;
    end else if (take) begin
      sum_q   <= sum_q + pix_ext;
      sumsq_q <= sumsq_q + pix_sq;
      cnt_q   <= cnt_q + CNT_W'(1);
    end
  end

  // State register and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      div_start_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      sqrt_start_q <= 1'b0;
      mean_tmp_q   <= '0;
      mean_q       <= '0;
      variance_q   <= '0;
    end else begin
      state_q      <= state_nxt;
      busy_q       <= busy_nxt;
      div_start_q  <= div_start_nxt;
      sqrt_start_q <= finish;
      if (bus.sof)     out_valid_q <= 1'b0;
      else if (finish) out_valid_q <= 1'b1;
      // First DIV_SQ cycle: the mean quotient is final and about to be overwritten.
      if ((state_q == DIV_SQ) && div_start_q) mean_tmp_q <= quotient[PIX_W-1:0];
      if (finish) begin
        mean_q     <= mean_tmp_q;
        variance_q <= var_calc;
      end
    end
  end

  seq_divider #(
    .DVD_W (SUM_W),
    .DVS_W (CNT_W)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start_q),
    .abort    (abort),
    .dividend (dividend),
    .divisor  (cnt_q),
    .quotient (quotient),
    .done     (div_done)
  );

  assign bus.busy       = busy_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.sqrt_start = sqrt_start_q;
  assign bus.mean       = mean_q;
  assign bus.variance   = variance_q;

endmodule
